// File: rtl/pmp_capture_pkg.sv
// Shared types and default sizes for the PMP capture controller.
package pmp_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int DEF_FIFO_AW     = 4;
  localparam int DEF_DECIM_W     = 16;
  localparam int DEF_FRAME_W     = 16;
  localparam int MIN_SYNC_STAGES = 2;

  function automatic logic [7:0] max_u8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pmp_sync_fifo.sv
// Single-clock byte FIFO with synchronous flush, registered occupancy and
// show-ahead head output; a full FIFO accepts a push when a pop happens too.
module pmp_sync_fifo
  import pmp_capture_pkg::*;
#(
  parameter int FIFO_AW = DEF_FIFO_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [FIFO_AW:0] count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // NOTE: storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (FIFO_AW+1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pmp_capture_ctrl.sv
// Armed, counted ADC capture frame served byte-per-request to the PIC PMP bus.
// Build option DECIM_PEAK_EN: push the window peak instead of the last sample.
module pmp_capture_ctrl
  import pmp_capture_pkg::*;
#(
  parameter int FIFO_AW     = DEF_FIFO_AW,
  parameter int DECIM_W     = DEF_DECIM_W,
  parameter int FRAME_W     = DEF_FRAME_W,
  parameter int SYNC_STAGES = MIN_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         adc_data,
  input  logic               adc_valid,
  input  logic [DECIM_W-1:0] decim_ratio,
  input  logic [FRAME_W-1:0] frame_len,
  input  logic               arm,
  input  logic               abort,
  input  logic               pmp_dreq,
  output logic [7:0]         pmp_d,
  output logic               pmp_strobe,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic               underrun,
  output logic [FIFO_AW:0]   fill_level
);

  // Fewer than two flops would not resolve metastability on the async request.
  localparam int SYNC_N = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
  localparam logic [FRAME_W-1:0] ONE_FRAME = FRAME_W'(1);

  state_e             state_q;
  logic [DECIM_W-1:0] ratio_q, dcnt_q;
  logic [FRAME_W-1:0] frame_len_q, fcnt_q, fcnt_inc;
  logic [SYNC_N-1:0]  dreq_sync_q;
  logic               dreq_prev_q;
  logic [7:0]         pmp_d_q;
  logic               strobe_q, busy_q, done_q, overflow_q, underrun_q;

  logic               req_rise, serve, capturing, eligible;
  logic               fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [7:0]         fifo_din, fifo_dout;
  logic [FIFO_AW:0]   fifo_count;

  assign req_rise   = dreq_sync_q[SYNC_N-1] & ~dreq_prev_q;
  assign serve      = req_rise & ~abort & ((state_q == ST_CAPTURE) || (state_q == ST_DRAIN));
  assign fifo_pop   = serve & ~fifo_empty;
  assign capturing  = (state_q == ST_CAPTURE) & ~abort;
  assign eligible   = capturing & adc_valid & (dcnt_q == ratio_q);
  assign fifo_push  = eligible;
  assign fifo_flush = abort | ((state_q == ST_IDLE) & arm);
  assign fcnt_inc   = fcnt_q + ONE_FRAME;

`ifdef DECIM_PEAK_EN
  logic [7:0] peak_q, window_max;

  // A new window starts whenever the decimation counter is back at zero.
  assign window_max = (dcnt_q == '0) ? adc_data : max_u8(peak_q, adc_data);
  assign fifo_din   = window_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          peak_q <= '0;
    else if (capturing && adc_valid)  peak_q <= window_max;
  end
`else
  assign fifo_din = adc_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dreq_sync_q <= '0;
      dreq_prev_q <= 1'b0;
    end else begin
      dreq_sync_q <= {dreq_sync_q[SYNC_N-2:0], pmp_dreq};
      dreq_prev_q <= dreq_sync_q[SYNC_N-1];
    end
  end

  pmp_sync_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ratio_q     <= '0;
      dcnt_q      <= '0;
      frame_len_q <= '0;
      fcnt_q      <= '0;
      pmp_d_q     <= '0;
      strobe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      strobe_q <= fifo_pop;
      if (fifo_pop) pmp_d_q <= fifo_dout;

      if (abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (arm) begin
              ratio_q     <= decim_ratio;
              frame_len_q <= (frame_len == '0) ? ONE_FRAME : frame_len;
              dcnt_q      <= '0;
              fcnt_q      <= '0;
              overflow_q  <= 1'b0;
              underrun_q  <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            if (adc_valid) dcnt_q <= eligible ? '0 : dcnt_q + DECIM_W'(1);
            if (eligible) begin
              fcnt_q <= fcnt_inc;
              if (fifo_full && !fifo_pop) overflow_q <= 1'b1;
              if (fcnt_inc == frame_len_q) state_q <= ST_DRAIN;
            end
            if (serve && fifo_empty) underrun_q <= 1'b1;
          end
          ST_DRAIN: begin
            if (serve && fifo_empty) underrun_q <= 1'b1;
            if (fifo_empty) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign pmp_d      = pmp_d_q;
  assign pmp_strobe = strobe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign underrun   = underrun_q;
  assign fill_level = fifo_count;

endmodule

// File: doc/pmp_capture_ctrl.md
Name: pmp_capture_ctrl

Overview:
Sequences one ADC capture frame and hands the samples to the PIC over the 8-bit PMP bus. The block decimates the ADC sample stream and buffers the decimated bytes in a small FIFO. It serves one byte for each PIC data request (pmp_dreq). It sits between the ADC front end and the PMP pins, and replaces the free-running gated latch with a counted, armed, flow-controlled transfer.

Parameters:
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW (16)
DECIM_W, 16, width of the decim_ratio input and the decimation counter
FRAME_W, 16, width of the frame_len input and the frame counter
SYNC_STAGES, 2, number of synchroniser flops on pmp_dreq (minimum 2)

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  asynchronous, active-high reset
adc_data  in  8  ADC sample
adc_valid  in  1  sample qualifier, one clk per sample
decim_ratio  in  DECIM_W  keep 1 of (decim_ratio+1) samples; sampled at arm
frame_len  in  FRAME_W  decimated samples per frame; sampled at arm; 0 is treated as 1
arm  in  1  start-frame pulse
abort  in  1  cancel pulse
pmp_dreq  in  1  PIC data request (asynchronous)
pmp_d  out  8  PMP data bus
pmp_strobe  out  1  one-clk pulse when pmp_d is updated
busy  out  1  high in CAPTURE or DRAIN
done  out  1  one-clk pulse at end of frame
overflow  out  1  sticky: sample dropped because the FIFO was full
underrun  out  1  sticky: request arrived with the FIFO empty
fill_level  out  FIFO_AW+1  current FIFO occupancy

Behaviour:
- Reset values: pmp_d=0, pmp_strobe=0, busy=0, done=0, overflow=0, underrun=0, fill_level=0. FSM=IDLE, FIFO empty, all counters 0.
- FSM states: IDLE, CAPTURE, DRAIN, DONE.
- IDLE + arm: latch decim_ratio and frame_len, flush FIFO, clear overflow/underrun, zero dcnt and fcnt, go to CAPTURE on the next clk. arm in any other state is ignored.
- abort in any state: next state IDLE, FIFO flushed, pmp_d held, sticky flags held. abort and arm in the same cycle: abort wins.
- CAPTURE, decimation: on each adc_valid, if dcnt==ratio then the sample is eligible and dcnt<=0; otherwise dcnt<=dcnt+1. A ratio of 0 makes every sample eligible.
- CAPTURE, eligible sample: pushed to the FIFO; if the FIFO is full and no pop occurs that cycle, the sample is dropped and overflow<=1. Every eligible sample increments fcnt, including dropped ones.
- CAPTURE exit: when fcnt reaches frame_len, go to DRAIN on the next clk. Samples after the last eligible sample are ignored.
- DRAIN: no pushes. When the FIFO is empty, go to DONE.
- DONE: done=1 for exactly one clk, then IDLE.
- pmp_dreq path: passes through SYNC_STAGES flops, then a rising-edge detect. Requests are served in CAPTURE and DRAIN only; a request in IDLE or DONE is ignored.
- Request served with the FIFO non-empty: pmp_d<=FIFO head, FIFO pops, pmp_strobe pulses high. pmp_d changes SYNC_STAGES+1 clks after the pmp_dreq rising edge.
- Request served with the FIFO empty: pmp_d holds, no strobe, underrun<=1. A push in the same cycle does not bypass to the output.
- FIFO full with push and pop in the same cycle: both occur, and occupancy stays at full with no overflow.
- fill_level: registered; it reflects a push or pop on the clk after the event.
- Counters wrap-safe: fcnt compares for equality; dcnt never exceeds the latched ratio.

Optional Feature:
DECIM_PEAK_EN
- Defined: each eligible sample is replaced by the unsigned maximum of all adc_data values in its decimation window (ratio+1 samples). The running maximum resets at each window start; this is peak-detect decimation, so glitches are not lost.
- Undefined: plain sample-drop decimation; the pushed value is the sample at dcnt==ratio. No peak register exists.

Decomposition:
- Shared package pmp_capture_pkg holds:
  - the FSM state encodings (ST_IDLE=0, ST_CAPTURE=1, ST_DRAIN=2, ST_DONE=3);
  - the default widths FIFO_AW/DECIM_W/FRAME_W;
  - the minimum SYNC_STAGES constant.
- One sub-module, pmp_sync_fifo: single-clock FIFO, 8-bit data, depth 2**FIFO_AW, with synchronous flush and registered count. Ports: push, pop, flush, din, dout, full, empty, count.
- The FSM, decimator, dreq synchroniser and edge detect stay in the top level.

Test Plan:
1. Basic frame: ratio=0, frame_len=4, samples 0x10..0x13, then 4 dreq edges -> pmp_d=0x10,0x11,0x12,0x13 each with one strobe. pmp_d changes 3 clks after each dreq edge. done pulses once and busy drops.
2. Decimation: ratio=2, frame_len=3, samples 0..8 -> FIFO holds 2,5,8, and pmp_d serves 2,5,8. With DECIM_PEAK_EN and samples 9,1,1,1,7,1,3,3,3 -> serves 9,7,3.
3. Overflow: ratio=0, frame_len=20, no dreq -> fill_level=16, overflow=1, state DRAIN. Draining 16 requests returns the first 16 samples, then done pulses.
4. Underrun: arm, issue a dreq before any adc_valid -> underrun=1, no strobe, pmp_d stays 0x00.
5. Abort mid-capture: frame_len=10, abort after 5 pushes -> next clk FSM is IDLE, fill_level=0, busy=0, no done pulse. A subsequent arm starts a clean frame.
6. Reset mid-drain: assert rst asynchronously with fill_level=6 -> all outputs return to reset values immediately, without waiting for a clk edge. A dreq after rst is released produces no strobe.
